// File: rtl/qs_pkg.sv
// Shared types for the quicksort bank scheduler: per-bank lifecycle state and
// index/count widths. The width localparams here set the port types of the scheduler.
package qs_pkg;

   localparam int QS_BANK_N = 2;
   localparam int QS_N      = 16;
   localparam int BANK_W    = (QS_BANK_N > 1) ? $clog2(QS_BANK_N) : 1;
   localparam int N_W       = $clog2(QS_N + 1);

   typedef logic [BANK_W-1:0] bank_n_t;
   typedef logic [N_W-1:0]    n_t;

   typedef enum logic [2:0] {
      BANK_IDLE      = 3'd0,
      BANK_LOADING   = 3'd1,
      BANK_READY     = 3'd2,
      BANK_SORTING   = 3'd3,
      BANK_SORTED    = 3'd4,
      BANK_UNLOADING = 3'd5
   } bank_status_t;

   typedef struct packed {
      bank_status_t status;
      n_t           n;
      logic         error;
   } bank_state_t;

   localparam bank_state_t BANK_STATE_RST = '{status: BANK_IDLE, n: '0, error: 1'b0};

   // Ring increment for a pointer over lim banks.
   function automatic bank_n_t bank_inc(bank_n_t p, int unsigned lim);
      return (int'(p) == int'(lim) - 1) ? '0 : p + bank_n_t'(1);
   endfunction

endpackage

// File: rtl/qs_bank_slot.sv
// One bank's lifecycle register. The scheduler only raises events that are legal
// for the current status, so at most one event hits a slot in any cycle.
module qs_bank_slot
   import qs_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enq_gnt_i,
   input  logic        enq_done_i,
   input  n_t          enq_n_i,
   input  logic        enq_error_i,
   input  logic        sort_start_i,
   input  logic        sort_skip_i,
   input  logic        sort_done_i,
   input  logic        deq_gnt_i,
   input  logic        deq_done_i,
   output bank_state_t state_o
);

   bank_state_t state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (enq_gnt_i) begin
         state_d.status = BANK_LOADING;
      end else if (enq_done_i) begin
         state_d.status = BANK_READY;
         state_d.n      = enq_n_i;
         state_d.error  = enq_error_i;
      end else if (sort_start_i) begin
         state_d.status = BANK_SORTING;
      end else if (sort_skip_i || sort_done_i) begin
         state_d.status = BANK_SORTED;
      end else if (deq_gnt_i) begin
         state_d.status = BANK_UNLOADING;
      end else if (deq_done_i) begin
         state_d = BANK_STATE_RST;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= BANK_STATE_RST;
      else     state_q <= state_d;
   end

   assign state_o = state_q;

endmodule

// File: rtl/qs_bank_sched.sv
// Rotates BANK_N sort banks through load -> sort -> unload in strict ring order,
// arbitrating between the enqueue, sort and dequeue engines.
module qs_bank_sched
   import qs_pkg::*;
#(
   parameter int BANK_N = QS_BANK_N,
   parameter int N      = QS_N
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enq_req,
   output logic                     enq_gnt,
   output bank_n_t                  enq_bank,
   input  logic                     enq_done,
   input  n_t                       enq_n,
   input  logic                     enq_error,
   output logic                     sort_start,
   output bank_n_t                  sort_bank,
   input  logic                     sort_done,
   input  logic                     deq_req,
   output logic                     deq_gnt,
   output bank_n_t                  deq_bank,
   output n_t                       deq_n,
   input  logic                     deq_done,
   output bank_state_t [BANK_N-1:0] bank_state_o,
   output logic                     proto_err
);

   bank_state_t [BANK_N-1:0] st;
   logic [BANK_N-1:0] ev_enq_gnt, ev_enq_done, ev_sort_start, ev_sort_skip;
   logic [BANK_N-1:0] ev_sort_done, ev_deq_gnt, ev_deq_done;

   bank_n_t enq_ptr_q, enq_ptr_d, enq_cpl_q, enq_cpl_d;
   bank_n_t sort_ptr_q, sort_ptr_d, sort_bank_q, sort_bank_d;
   bank_n_t deq_ptr_q, deq_ptr_d, deq_cpl_q, deq_cpl_d;
   logic    sort_busy_q, sort_busy_d, proto_err_q, proto_err_d;

   logic enq_ok, sort_ok, deq_ok, sort_rdy, sort_skip;
   n_t   enq_n_c;

   // Completion pointers track the oldest LOADING / UNLOADING bank, which is
   // ptr-1 whenever only one transfer is in flight.
   always_comb begin
      enq_gnt    = !rst && enq_req && (st[enq_ptr_q].status == BANK_IDLE);
      enq_bank   = enq_ptr_q;
      sort_rdy   = !rst && !sort_busy_q && (st[sort_ptr_q].status == BANK_READY);
      sort_skip  = sort_rdy && ((st[sort_ptr_q].n == '0) || st[sort_ptr_q].error);
      sort_start = sort_rdy && !sort_skip;
      sort_bank  = sort_ptr_q;
      deq_gnt    = !rst && deq_req && (st[deq_ptr_q].status == BANK_SORTED);
      deq_bank   = deq_ptr_q;
      deq_n      = st[deq_ptr_q].n;
      enq_ok     = enq_done && (st[enq_cpl_q].status == BANK_LOADING);
      sort_ok    = sort_done && sort_busy_q && (st[sort_bank_q].status == BANK_SORTING);
      deq_ok     = deq_done && (st[deq_cpl_q].status == BANK_UNLOADING);
      enq_n_c    = (enq_n > n_t'(N)) ? n_t'(N) : enq_n;
   end

   always_comb begin
      ev_enq_gnt    = '0;
      ev_enq_done   = '0;
      ev_sort_start = '0;
      ev_sort_skip  = '0;
      ev_sort_done  = '0;
      ev_deq_gnt    = '0;
      ev_deq_done   = '0;
      if (enq_gnt)    ev_enq_gnt[enq_ptr_q]     = 1'b1;
      if (enq_ok)     ev_enq_done[enq_cpl_q]    = 1'b1;
      if (sort_start) ev_sort_start[sort_ptr_q] = 1'b1;
      if (sort_skip)  ev_sort_skip[sort_ptr_q]  = 1'b1;
      if (sort_ok)    ev_sort_done[sort_bank_q] = 1'b1;
      if (deq_gnt)    ev_deq_gnt[deq_ptr_q]     = 1'b1;
      if (deq_ok)     ev_deq_done[deq_cpl_q]    = 1'b1;
   end

   always_comb begin
      enq_ptr_d   = enq_gnt  ? bank_inc(enq_ptr_q, BANK_N)  : enq_ptr_q;
      enq_cpl_d   = enq_ok   ? bank_inc(enq_cpl_q, BANK_N)  : enq_cpl_q;
      sort_ptr_d  = sort_rdy ? bank_inc(sort_ptr_q, BANK_N) : sort_ptr_q;
      deq_ptr_d   = deq_gnt  ? bank_inc(deq_ptr_q, BANK_N)  : deq_ptr_q;
      deq_cpl_d   = deq_ok   ? bank_inc(deq_cpl_q, BANK_N)  : deq_cpl_q;
      sort_bank_d = sort_start ? sort_ptr_q : sort_bank_q;
      sort_busy_d = sort_busy_q;
      if (sort_start)   sort_busy_d = 1'b1;
      else if (sort_ok) sort_busy_d = 1'b0;
      proto_err_d = proto_err_q | (enq_done && !enq_ok) | (sort_done && !sort_ok)
                  | (deq_done && !deq_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enq_ptr_q   <= '0;
         enq_cpl_q   <= '0;
         sort_ptr_q  <= '0;
         sort_bank_q <= '0;
         deq_ptr_q   <= '0;
         deq_cpl_q   <= '0;
         sort_busy_q <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         enq_ptr_q   <= enq_ptr_d;
         enq_cpl_q   <= enq_cpl_d;
         sort_ptr_q  <= sort_ptr_d;
         sort_bank_q <= sort_bank_d;
         deq_ptr_q   <= deq_ptr_d;
         deq_cpl_q   <= deq_cpl_d;
         sort_busy_q <= sort_busy_d;
         proto_err_q <= proto_err_d;
      end
   end

   for (genvar b = 0; b < BANK_N; b++) begin : g_slot
      qs_bank_slot u_slot (
         .clk          (clk),
         .rst          (rst),
         .enq_gnt_i    (ev_enq_gnt[b]),
         .enq_done_i   (ev_enq_done[b]),
         .enq_n_i      (enq_n_c),
         .enq_error_i  (enq_error),
         .sort_start_i (ev_sort_start[b]),
         .sort_skip_i  (ev_sort_skip[b]),
         .sort_done_i  (ev_sort_done[b]),
         .deq_gnt_i    (ev_deq_gnt[b]),
         .deq_done_i   (ev_deq_done[b]),
         .state_o      (st[b])
      );
   end

   assign bank_state_o = st;
   assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_qs_bank_sched.sv
// Directed bench for qs_bank_sched: load/sort/unload flow, full-ring backpressure,
// sort bypass, protocol errors and mid-flight reset, with a dequeue scoreboard.
module tb_qs_bank_sched;
   import qs_pkg::*;

   typedef struct packed {
      bank_n_t bank;
      n_t      n;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enq_req = 0, enq_done = 0, enq_error = 0, sort_done = 0, deq_req = 0, deq_done = 0;
   n_t   enq_n = '0;
   logic enq_gnt, sort_start, deq_gnt, proto_err;
   bank_n_t enq_bank, sort_bank, deq_bank;
   n_t   deq_n;
   bank_state_t [1:0] bso;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   qs_bank_sched #(.BANK_N(2), .N(16)) dut (
      .clk(clk), .rst(rst),
      .enq_req(enq_req), .enq_gnt(enq_gnt), .enq_bank(enq_bank),
      .enq_done(enq_done), .enq_n(enq_n), .enq_error(enq_error),
      .sort_start(sort_start), .sort_bank(sort_bank), .sort_done(sort_done),
      .deq_req(deq_req), .deq_gnt(deq_gnt), .deq_bank(deq_bank), .deq_n(deq_n),
      .deq_done(deq_done), .bank_state_o(bso), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input int b, input bank_status_t exp);
      chk(tag, 32'(bso[b].status), 32'(exp));
   endtask

   // Expect a dequeue grant now and compare it with the oldest loaded bank.
   task automatic chk_deq(input string tag);
      exp_t e;
      chk({tag, "_gnt"}, 32'(deq_gnt), 32'd1);
      n_tests++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL %s_sb: got empty scoreboard expected an entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_bank"}, 32'(deq_bank), 32'(e.bank));
         chk({tag, "_n"}, 32'(deq_n), 32'(e.n));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state, grants held off while rst is high
      enq_req = 1'b1;
      tick();
      chk("rst_enq_gnt", 32'(enq_gnt), 32'd0);
      enq_req = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      chk_st("rst_b0", 0, BANK_IDLE);
      chk_st("rst_b1", 1, BANK_IDLE);
      chk("rst_n0", 32'(bso[0].n), 32'd0);
      chk("rst_perr", 32'(proto_err), 32'd0);
      chk("rst_sort_start", 32'(sort_start), 32'd0);

      // single bank through the whole pipeline
      enq_req = 1'b1; #1;
      chk("e1_gnt", 32'(enq_gnt), 32'd1);
      chk("e1_bank", 32'(enq_bank), 32'd0);
      tick(); enq_req = 1'b0; #1;
      chk_st("e1_loading", 0, BANK_LOADING);
      enq_done = 1'b1; enq_n = 5; sb.push_back('{bank: 0, n: 5});
      tick(); enq_done = 1'b0; #1;
      chk_st("e1_ready", 0, BANK_READY);
      chk("e1_sort_start", 32'(sort_start), 32'd1);
      chk("e1_sort_bank", 32'(sort_bank), 32'd0);
      tick();
      chk("e1_sort_pulse", 32'(sort_start), 32'd0);
      chk_st("e1_sorting", 0, BANK_SORTING);
      tick();
      sort_done = 1'b1;
      tick(); sort_done = 1'b0; #1;
      chk_st("e1_sorted", 0, BANK_SORTED);
      deq_req = 1'b1; #1;
      chk_deq("e1_deq");
      tick(); deq_req = 1'b0; #1;
      chk_st("e1_unloading", 0, BANK_UNLOADING);
      deq_done = 1'b1;
      tick(); deq_done = 1'b0; #1;
      chk_st("e1_idle", 0, BANK_IDLE);
      chk("e1_perr", 32'(proto_err), 32'd0);

      // both banks occupied: held enq_req gets no grant until bank0 drains
      do_reset();
      enq_req = 1'b1; #1;
      chk("f_gnt0", 32'(enq_gnt), 32'd1);
      tick(); enq_req = 1'b0;
      enq_done = 1'b1; enq_n = 3; sb.push_back('{bank: 0, n: 3});
      tick(); enq_done = 1'b0; enq_req = 1'b1; #1;
      chk("f_gnt1", 32'(enq_gnt), 32'd1);
      chk("f_bank1", 32'(enq_bank), 32'd1);
      chk("f_sort0", 32'(sort_start), 32'd1);
      tick();
      enq_done = 1'b1; enq_n = 3; sb.push_back('{bank: 1, n: 3}); #1;
      chk("f_full_a", 32'(enq_gnt), 32'd0);
      tick(); enq_done = 1'b0; sort_done = 1'b1; #1;
      chk("f_full_b", 32'(enq_gnt), 32'd0);
      chk("f_no_sort_busy", 32'(sort_start), 32'd0);
      tick(); sort_done = 1'b0; #1;
      chk("f_sort1", 32'(sort_start), 32'd1);
      chk("f_sort1_bank", 32'(sort_bank), 32'd1);
      deq_req = 1'b1; #1;
      chk_deq("f_deq0");
      chk("f_full_c", 32'(enq_gnt), 32'd0);
      tick(); deq_req = 1'b0; deq_done = 1'b1; #1;
      chk("f_full_d", 32'(enq_gnt), 32'd0);
      tick(); deq_done = 1'b0; #1;
      chk("f_regnt", 32'(enq_gnt), 32'd1);
      chk("f_regnt_bank", 32'(enq_bank), 32'd0);
      tick(); enq_req = 1'b0; #1;
      chk_st("f_b1_sorting", 1, BANK_SORTING);

      // reset while bank1 is sorting
      rst = 1'b1; #1;
      chk("r_sort_start", 32'(sort_start), 32'd0);
      tick(); rst = 1'b0; sb.delete(); #1;
      chk_st("r_b0", 0, BANK_IDLE);
      chk_st("r_b1", 1, BANK_IDLE);
      chk("r_sort_start2", 32'(sort_start), 32'd0);
      enq_req = 1'b1; #1;
      chk("r_enq_ptr", 32'(enq_bank), 32'd0);
      enq_req = 1'b0;
      sort_done = 1'b1;
      tick(); sort_done = 1'b0; #1;
      chk("r_late_done_perr", 32'(proto_err), 32'd1);
      chk_st("r_b1_unch", 1, BANK_IDLE);

      // empty and errored loads bypass the sorter
      do_reset();
      chk("z_perr_clr", 32'(proto_err), 32'd0);
      deq_req = 1'b1; #1;
      chk("z_no_sorted", 32'(deq_gnt), 32'd0);
      deq_req = 1'b0; enq_req = 1'b1;
      tick(); enq_req = 1'b0;
      enq_done = 1'b1; enq_n = 0; sb.push_back('{bank: 0, n: 0});
      tick(); enq_done = 1'b0; #1;
      chk_st("z_ready", 0, BANK_READY);
      chk("z_no_start", 32'(sort_start), 32'd0);
      tick();
      chk_st("z_sorted", 0, BANK_SORTED);
      chk("z_no_start2", 32'(sort_start), 32'd0);
      enq_req = 1'b1;
      tick(); enq_req = 1'b0;
      enq_done = 1'b1; enq_n = 7; enq_error = 1'b1; sb.push_back('{bank: 1, n: 7});
      tick(); enq_done = 1'b0; enq_error = 1'b0; #1;
      chk("x_err_latched", 32'(bso[1].error), 32'd1);
      chk("x_no_start", 32'(sort_start), 32'd0);
      tick();
      chk_st("x_sorted", 1, BANK_SORTED);
      deq_req = 1'b1; #1;
      chk_deq("z_deq0");
      tick(); deq_req = 1'b0; deq_done = 1'b1;
      tick(); deq_done = 1'b0; #1;

      // stray sort_done: sticky proto_err, state untouched
      sort_done = 1'b1;
      tick(); sort_done = 1'b0; #1;
      chk("p_perr", 32'(proto_err), 32'd1);
      chk_st("p_b1_unch", 1, BANK_SORTED);
      chk("p_b1_n_unch", 32'(bso[1].n), 32'd7);
      chk_st("p_b0_unch", 0, BANK_IDLE);
      tick(); tick();
      chk("p_perr_sticky", 32'(proto_err), 32'd1);
      deq_req = 1'b1; #1;
      chk_deq("x_deq1");
      tick(); deq_req = 1'b0; deq_done = 1'b1;
      tick(); deq_done = 1'b0; #1;
      chk_st("x_b1_idle", 1, BANK_IDLE);
      chk("x_b1_err_clr", 32'(bso[1].error), 32'd0);
      do_reset();
      chk("p_perr_rst", 32'(proto_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/qs_bank_sched.md
QS_BANK_SCHED -- requirements
Module: qs_bank_sched

Interface
REQ-001 SHALL have parameter BANK_N, default 2: number of sort banks; power of two, at least 2.
REQ-002 SHALL have parameter N, default 16: maximum entries per bank.
REQ-003 SHALL have ports clk (in, 1), the single clock, and rst (in, 1), the reset; reset is synchronous and active-high.
REQ-004 SHALL have enq_req (in, 1) and enq_gnt (out, 1): enqueue engine requests a free bank.
REQ-005 SHALL have enq_bank (out, bank_n_t): the bank granted to enqueue.
REQ-006 SHALL have enq_done (in, 1), enq_n (in, n_t) and enq_error (in, 1): the load completes with entry count and error flag.
REQ-007 SHALL have sort_start (out, 1) and sort_bank (out, bank_n_t): one-cycle command to the sort engine.
REQ-008 SHALL have sort_done (in, 1): the sort engine has finished the current bank.
REQ-009 SHALL have deq_req (in, 1), deq_gnt (out, 1), deq_bank (out, bank_n_t) and deq_n (out, n_t): dequeue engine requests a sorted bank and receives its count.
REQ-010 SHALL have deq_done (in, 1): the unload completes.
REQ-011 SHALL have bank_state_o (out, BANK_N x bank_state_t): per-bank state for observability.
REQ-012 SHALL have proto_err (out, 1): sticky protocol-violation flag.

Function
REQ-013 SHALL hold a bank_state_t record per bank: status, n and error.
REQ-014 SHALL hold enq_ptr, sort_ptr and deq_ptr (bank_n_t); each SHALL advance by +1 modulo BANK_N on its own grant/start only.
REQ-015 enq_gnt SHALL equal enq_req AND status[enq_ptr]==BANK_IDLE, combinationally; enq_bank SHALL equal enq_ptr.
REQ-016 On enq_gnt, status[enq_ptr] SHALL become BANK_LOADING at the next edge.
REQ-017 On enq_done, the single LOADING bank (the one at enq_ptr-1) SHALL become BANK_READY and latch n=enq_n and error=enq_error.
REQ-018 With the sorter idle and status[sort_ptr]==BANK_READY: if n==0 or error=1, the bank SHALL go directly to BANK_SORTED with no sort_start; otherwise sort_start SHALL pulse for one cycle, sort_bank=sort_ptr, the status SHALL become BANK_SORTING, and the sorter SHALL be marked busy.
REQ-019 On sort_done, the SORTING bank SHALL become BANK_SORTED and the sorter SHALL be marked idle; a new sort_start SHALL NOT be issued earlier than the cycle after sort_done.
REQ-020 deq_gnt SHALL equal deq_req AND status[deq_ptr]==BANK_SORTED; deq_bank SHALL equal deq_ptr and deq_n SHALL equal n[deq_ptr].
REQ-021 On deq_gnt, the bank SHALL become BANK_UNLOADING; on deq_done, the UNLOADING bank SHALL become BANK_IDLE with n and error cleared.
REQ-022 Banks SHALL be dequeued in the same order they were loaded.
REQ-023 Events on different banks in the same cycle SHALL all apply.
REQ-024 A state written at an edge SHALL be acted on no earlier than the following cycle: done-to-next-stage latency is at least 1 cycle.
REQ-025 enq_done, sort_done or deq_done arriving with no bank in the matching state SHALL be ignored for state and SHALL set proto_err.
REQ-026 When every bank is occupied, enq_gnt SHALL stay 0 until a deq_done frees a bank.
REQ-027 When no bank is SORTED, deq_gnt SHALL stay 0.

Reset
REQ-028 On rst: all banks SHALL be BANK_IDLE with n=0 and error=0; all pointers SHALL be 0; the sorter SHALL be idle; proto_err SHALL be 0; enq_gnt, deq_gnt and sort_start SHALL be 0.
REQ-029 Reset mid-operation SHALL abandon all in-flight banks without emitting further sort_start.

Structure
REQ-030 bank_state_t, bank_status_t, bank_n_t and n_t SHALL come from qs_pkg; any added scheduler typedefs SHALL also be placed in qs_pkg.
REQ-031 The per-bank status register and its next-state logic SHALL be a sub-module, qs_bank_slot, instantiated BANK_N times.

Verification
REQ-032 Reset, then enq_req=1 -> enq_gnt=1 in the same cycle with enq_bank=0; bank0 becomes LOADING at the next edge.
REQ-033 enq_done with enq_n=5 on bank0 -> one cycle later sort_start=1 with sort_bank=0; sort_done -> bank0 becomes SORTED; deq_req -> deq_gnt=1 with deq_n=5.
REQ-034 Load bank0 and bank1 (enq_n=3 each) and hold enq_req=1 -> a third grant stays 0 until deq_done on bank0, then enq_gnt=1 with enq_bank=0.
REQ-035 enq_done with enq_n=0 -> no sort_start; the bank goes READY to SORTED directly; deq_n=0.
REQ-036 sort_done with no bank SORTING -> proto_err=1 and stays set until rst; all bank states unchanged.
REQ-037 Assert rst while bank1 is SORTING -> the next cycle shows all IDLE, all pointers 0, sort_start=0; a later sort_done is flagged as proto_err.
